// File: rtl/seq_scan_pkg.sv
// -----------------------------------------------------------------------------
// seq_scan_pkg
// Shared definitions for the word-level serial pattern scanner.
//   state_t         : controller FSM encoding (IDLE / SHIFT / DONE)
//   PAT_LEN         : length of the detected bit pattern
//   FIRST_IDX_NONE  : no-match sentinel for out_first_idx (truncate to IDX_W)
// -----------------------------------------------------------------------------
package seq_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int PAT_LEN = 3;

    // All-ones means "no counted match in this word".
    localparam logic [31:0] FIRST_IDX_NONE = '1;

endpackage

// File: rtl/seq_det_core.sv
// -----------------------------------------------------------------------------
// seq_det_core
// Serial detection engine: a PAT_LEN-bit window fed one bit per enabled cycle,
// a fill counter (bits shifted since clear) and a gap counter (bits shifted
// since the last counted match). Raises a single-cycle combinational match
// strobe in the cycle whose shifted bit completes a counted match.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   clear      : empty window and counters (start of a new word)
//   shift_en   : shift bit_in into the window this cycle
//   bit_in     : next serial bit
//   pattern    : target pattern, MSB is first bit in time
//   overlap    : 1 = overlapping matches allowed
//   match      : this cycle's bit completes a counted match
// -----------------------------------------------------------------------------
import seq_scan_pkg::*;

module seq_det_core (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               shift_en,
    input  logic               bit_in,
    input  logic [PAT_LEN-1:0] pattern,
    input  logic               overlap,
    output logic               match
);

    localparam int CW = $clog2(PAT_LEN + 1);
    localparam logic [CW-1:0] FULL = CW'(PAT_LEN);

    logic [PAT_LEN-1:0] window, win_nxt;
    logic [CW-1:0]      fill, fill_nxt;
    logic [CW-1:0]      gap, gap_nxt;

    // Both counters saturate at PAT_LEN: only "at least PAT_LEN" matters.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        win_nxt  = window;
        fill_nxt = fill;
        gap_nxt  = gap;
        match    = 1'b0;
        if (shift_en) begin
            win_nxt  = {window[PAT_LEN-2:0], bit_in};
            fill_nxt = (fill == FULL) ? fill : fill + 1'b1;
            gap_nxt  = (gap  == FULL) ? gap  : gap  + 1'b1;
            match    = (fill_nxt == FULL) && (win_nxt == pattern) &&
                       (overlap || (gap_nxt == FULL));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            window <= '0;
            fill   <= '0;
            gap    <= '0;
        end else if (clear) begin
            window <= '0;
            fill   <= '0;
            gap    <= '0;
        end else if (shift_en) begin
            window <= win_nxt;
            fill   <= fill_nxt;
            // Gap restarts only on a counted match.
            gap    <= match ? '0 : gap_nxt;
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seq_scan_ctrl
// Word-level controller for the serial pattern detector. Accepts a word over a
// valid/ready handshake, shifts it MSB-first through seq_det_core one bit per
// clock, counts matches (saturating) and returns the count over a second
// valid/ready handshake.
// Optional feature macro: SEQ_SCAN_FIRST_IDX_EN adds out_first_idx, the step
// index of the bit that completed the first counted match (all-ones if none).
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   in_valid/in_ready : word handshake (ready only while idle)
//   in_word           : word to scan, bit WORD_W-1 first
//   cfg_pattern       : 3-bit target pattern, bit 2 first in time
//   cfg_overlap       : 1 = overlapping, 0 = non-overlapping detection
//   out_valid/out_ready : result handshake
//   out_count         : matches in the word
//   out_first_idx     : first match step index (macro only)
// -----------------------------------------------------------------------------
import seq_scan_pkg::*;

module seq_scan_ctrl #(
    parameter  int WORD_W = 16,
    parameter  int CNT_W  = 5,
    localparam int IDX_W  = $clog2(WORD_W) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_word,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic               cfg_overlap,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   out_count
`ifdef SEQ_SCAN_FIRST_IDX_EN
    ,
    output logic [IDX_W-1:0]   out_first_idx
`endif
);

    localparam int SW = $clog2(WORD_W);
    localparam logic [SW-1:0] LAST_STEP = SW'(WORD_W - 1);

    state_t             state;
    logic [WORD_W-1:0]  shreg;
    logic [SW-1:0]      step;
    logic [PAT_LEN-1:0] pat_q;
    logic               ovl_q;
    logic               accept;
    logic               match;

`ifdef SEQ_SCAN_FIRST_IDX_EN
    localparam logic [IDX_W-1:0] IDX_NONE = FIRST_IDX_NONE[IDX_W-1:0];
`endif

    assign accept = (state == IDLE) && in_valid && in_ready;

    seq_det_core u_core (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .shift_en (state == SHIFT),
        .bit_in   (shreg[WORD_W-1]),
        .pattern  (pat_q),
        .overlap  (ovl_q),
        .match    (match)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the word/config latches are reset too even though they are
            // reloaded on every accept; this keeps simulation X-free and costs
            // nothing on a handful of flops (unlike a RAM, which is never reset).
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_count <= '0;
            shreg     <= '0;
            step      <= '0;
            pat_q     <= '0;
            ovl_q     <= 1'b0;
`ifdef SEQ_SCAN_FIRST_IDX_EN
            out_first_idx <= IDX_NONE;
`endif
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        shreg     <= in_word;
                        pat_q     <= cfg_pattern;
                        ovl_q     <= cfg_overlap;
                        out_count <= '0;
                        step      <= '0;
                        in_ready  <= 1'b0;
                        state     <= SHIFT;
`ifdef SEQ_SCAN_FIRST_IDX_EN
                        out_first_idx <= IDX_NONE;
`endif
                    end
                end

                SHIFT: begin
                    shreg <= shreg << 1;
                    step  <= step + 1'b1;
                    if (match) begin
                        if (out_count != '1)
                            out_count <= out_count + 1'b1;
`ifdef SEQ_SCAN_FIRST_IDX_EN
                        if (out_first_idx == IDX_NONE)
                            out_first_idx <= IDX_W'(step);
`endif
                    end
                    if (step == LAST_STEP) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    // Ready rises on the handshake edge; the next word can be
                    // accepted one cycle later at the earliest.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    out_count <= '0;
                    shreg     <= '0;
                    step      <= '0;
                    pat_q     <= '0;
                    ovl_q     <= 1'b0;
`ifdef SEQ_SCAN_FIRST_IDX_EN
                    out_first_idx <= IDX_NONE;
`endif
                end
            endcase
        end
    end

endmodule
